// File: rtl/gen3_block_framer_pkg.sv
// gen3_block_framer_pkg: sync-header encodings and block geometry shared by the Gen3 framer.
package gen3_block_framer_pkg;
  localparam logic [1:0] SYNC_HDR_DATA = 2'b10;
  localparam logic [1:0] SYNC_HDR_OS = 2'b01;
  localparam int GEN3_WORDS_PER_BLOCK = 4;
  localparam int WORD_W = 32;
  localparam int HDR_W = 2;
  function automatic logic [HDR_W-1:0] sync_hdr(input logic os);
    return os ? SYNC_HDR_OS : SYNC_HDR_DATA;
  endfunction
endpackage

// File: rtl/gen3_gearbox_130_32.sv
// gen3_gearbox_130_32: accumulator gearbox packing 130-bit blocks onto a 32-bit stream.
// BLOCK_MARK_EN adds block_start_o/hdr_offset_o marking the word carrying header bit0.
module gen3_gearbox_130_32
  import gen3_block_framer_pkg::*;
#(
  parameter int ACC_W = 128,
  parameter int LW = $clog2(ACC_W + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    push_i,
  input  logic                    first_i,
  input  logic [WORD_W+HDR_W-1:0] bits_i,
  output logic [LW-1:0]           level_o,
  output logic [WORD_W-1:0]       data_o,
  output logic                    valid_o
`ifdef BLOCK_MARK_EN
  ,
  output logic                    block_start_o,
  output logic [4:0]              hdr_offset_o
`endif
);
  logic [ACC_W-1:0] r_acc;
  logic [LW-1:0] r_level;
  logic w_emit;
  logic [LW-1:0] w_lvl_s;
  logic [ACC_W-1:0] w_acc_s;
  logic [ACC_W-1:0] w_ins;
  // New bits land at the post-shift level, so emit and append in one cycle lose nothing.
  always_comb begin
    w_emit = r_level >= LW'(WORD_W);
    w_lvl_s = w_emit ? r_level - LW'(WORD_W) : r_level;
    w_acc_s = w_emit ? r_acc >> WORD_W : r_acc;
    w_ins = push_i ? ACC_W'(bits_i) << w_lvl_s : '0;
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_acc <= '0;
      r_level <= '0;
    end else begin
      r_acc <= w_acc_s | w_ins;
      r_level <= w_lvl_s + (push_i ? (first_i ? LW'(WORD_W + HDR_W) : LW'(WORD_W)) : '0);
    end
  end
  assign level_o = r_level;
  assign data_o = r_acc[WORD_W-1:0];
  assign valid_o = w_emit;
`ifdef BLOCK_MARK_EN
  logic r_mark;
  logic [4:0] r_off;
  // A header always lands below bit 32 and the level then exceeds 32, so it leaves next cycle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_mark <= 1'b0;
      r_off <= '0;
    end else begin
      r_mark <= push_i && first_i;
      r_off <= (push_i && first_i) ? w_lvl_s[4:0] : '0;
    end
  end
  assign block_start_o = r_mark;
  assign hdr_offset_o = r_off;
`endif
endmodule

// File: rtl/gen3_block_framer.sv
// gen3_block_framer: Gen3 128b/130b framer with sync-header insertion and 130->32 gearbox.
// BLOCK_MARK_EN adds block_start_o/hdr_offset_o header-position outputs.
module gen3_block_framer
  import gen3_block_framer_pkg::*;
#(
  parameter int ACC_W = 128,
  parameter int READY_THRESH = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [WORD_W-1:0] data_i,
  input  logic              valid_i,
  input  logic              os_block_i,
  output logic              ready_o,
  output logic [WORD_W-1:0] data_o,
  output logic              valid_o
`ifdef BLOCK_MARK_EN
  ,
  output logic              block_start_o,
  output logic [4:0]        hdr_offset_o
`endif
);
  localparam int LW = $clog2(ACC_W + 1);
  logic [1:0] r_word_cnt;
  logic [LW-1:0] w_level;
  logic w_accept;
  logic w_first;
  logic [WORD_W+HDR_W-1:0] w_bits;
  assign ready_o = w_level < LW'(READY_THRESH);
  always_comb begin
    w_accept = valid_i && ready_o;
    w_first = r_word_cnt == '0;
    w_bits = w_first ? {data_i, sync_hdr(os_block_i)} : {{HDR_W{1'b0}}, data_i};
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_word_cnt <= '0;
    else if (w_accept) r_word_cnt <= (r_word_cnt == 2'(GEN3_WORDS_PER_BLOCK - 1)) ? '0 : r_word_cnt + 2'd1;
  end
  gen3_gearbox_130_32 #(.ACC_W(ACC_W), .LW(LW)) u_gearbox (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .push_i(w_accept),
    .first_i(w_first),
    .bits_i(w_bits),
    .level_o(w_level),
    .data_o(data_o),
    .valid_o(valid_o)
`ifdef BLOCK_MARK_EN
    ,
    .block_start_o(block_start_o),
    .hdr_offset_o(hdr_offset_o)
`endif
  );
endmodule

// File: tb/tb_gen3_block_framer.sv
// tb_gen3_block_framer: scoreboard bench; expected words come from a bit-level model of the 130-bit blocks.
module tb_gen3_block_framer;
  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  logic [31:0] data_i = '0;
  logic valid_i = 1'b0;
  logic os_block_i = 1'b0;
  logic ready_o;
  logic [31:0] data_o;
  logic valid_o;
`ifdef BLOCK_MARK_EN
  logic block_start_o;
  logic [4:0] hdr_offset_o;
  int off_q[$];
`endif
  typedef struct packed {
    logic [31:0] d;
    logic m;
    logic [4:0] off;
  } exp_t;
  exp_t exp_q[$];
  logic bq[$];
  logic mq[$];
  logic [31:0] cap_q[$];
  logic [31:0] ref_q[$];
  int checks = 0;
  int errors = 0;
  int n_valid = 0;
  int n_rdy_low = 0;
  int n_stall = 0;
  int bench_wc = 0;
  logic [31:0] first_word = '0;
  logic got_first = 1'b0;

  always #5 clk_i = ~clk_i;

  gen3_block_framer dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .data_i(data_i),
    .valid_i(valid_i),
    .os_block_i(os_block_i),
    .ready_o(ready_o),
    .data_o(data_o),
    .valid_o(valid_o)
`ifdef BLOCK_MARK_EN
    ,
    .block_start_o(block_start_o),
    .hdr_offset_o(hdr_offset_o)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Header bit0 is sent first: data hdr 2'b10 -> 0,1; OS hdr 2'b01 -> 1,0.
  function automatic void model_push(input logic [31:0] d, input logic os);
    exp_t e;
    if (bench_wc == 0) begin
      bq.push_back(os);
      mq.push_back(1'b1);
      bq.push_back(~os);
      mq.push_back(1'b0);
    end
    for (int i = 0; i < 32; i++) begin
      bq.push_back(d[i]);
      mq.push_back(1'b0);
    end
    bench_wc = (bench_wc + 1) % 4;
    while (bq.size() >= 32) begin
      e = '0;
      for (int i = 0; i < 32; i++) begin
        e.d[i] = bq.pop_front();
        if (mq.pop_front()) begin
          e.m = 1'b1;
          e.off = 5'(i);
        end
      end
      exp_q.push_back(e);
    end
  endfunction

  always @(negedge clk_i) begin
    exp_t e;
    if (rst_i) begin
      if (!ready_o) n_rdy_low++;
      if (valid_o) begin
        n_valid++;
        cap_q.push_back(data_o);
        if (!got_first) begin
          first_word = data_o;
          got_first = 1'b1;
        end
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %h expected none", data_o);
        end else begin
          e = exp_q.pop_front();
          chk("data_o", data_o, e.d);
`ifdef BLOCK_MARK_EN
          chk("block_start_o", 32'(block_start_o), 32'(e.m));
          chk("hdr_offset_o", 32'(hdr_offset_o), e.m ? 32'(e.off) : 32'd0);
          if (block_start_o) off_q.push_back(int'(hdr_offset_o));
`endif
        end
      end
`ifdef BLOCK_MARK_EN
      else chk("block_start_idle", 32'(block_start_o), 32'd0);
`endif
    end
  end

  task automatic do_reset(input string tag);
    valid_i = 1'b0;
    #2 rst_i = 1'b0;
    #1;
    chk({tag, "_rst_valid"}, 32'(valid_o), 32'd0);
    chk({tag, "_rst_data"}, data_o, 32'd0);
    chk({tag, "_rst_ready"}, 32'(ready_o), 32'd1);
`ifdef BLOCK_MARK_EN
    chk({tag, "_rst_mark"}, 32'(block_start_o), 32'd0);
    chk({tag, "_rst_off"}, 32'(hdr_offset_o), 32'd0);
    off_q.delete();
`endif
    exp_q.delete();
    bq.delete();
    mq.delete();
    bench_wc = 0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    n_valid = 0;
    n_rdy_low = 0;
    n_stall = 0;
    got_first = 1'b0;
    cap_q.delete();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic os);
    int t = 0;
    logic r;
    valid_i = 1'b1;
    data_i = d;
    os_block_i = os;
    do begin
      @(negedge clk_i);
      r = ready_o;
      if (!r) n_stall++;
      @(posedge clk_i);
      t++;
    end while (!r && t < 20);
    if (!r) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got ready 0 expected 1 within 20 cycles");
    end else model_push(d, os);
    #1;
  endtask

  task automatic idle(input int n);
    valid_i = 1'b0;
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic stream(input int n);
    for (int i = 0; i < n; i++)
      send(32'h1000_0000 + 32'(i) * 32'h0103_0507,
           ((i % 4) == 0) ? ((i / 4) % 3 == 1) : (i % 2 == 1));
    idle(12);
  endtask

  initial begin
    do_reset("t1");
    repeat (4) send(32'h0, 1'b0);
    idle(8);
    chk("t1_first", first_word, 32'h0000_0002);
    chk("t1_nvalid", 32'(n_valid), 32'd4);
    chk("t1_drained", 32'(exp_q.size()), 32'd0);
    send(32'hA5A5_A5A5, 1'b1);
    send(32'h0123_4567, 1'b0);
    send(32'h89AB_CDEF, 1'b1);
    send(32'hDEAD_BEEF, 1'b0);
    idle(8);
    chk("t1_residual_nvalid", 32'(n_valid), 32'd8);
    do_reset("t2");
    repeat (4) send(32'hFFFF_FFFF, 1'b1);
    idle(8);
    chk("t2_first", first_word, 32'hFFFF_FFFD);
    chk("t2_nvalid", 32'(n_valid), 32'd4);
    do_reset("t3");
    stream(64);
    chk("t3_ready_low", 32'(n_rdy_low), 32'd1);
    chk("t3_nvalid", 32'(n_valid), 32'd65);
    chk("t3_drained", 32'(exp_q.size()), 32'd0);
`ifdef BLOCK_MARK_EN
    chk("t6_nmarks", 32'(off_q.size()), 32'd16);
    for (int k = 0; k < off_q.size(); k++) chk("t6_offset_seq", 32'(off_q[k]), 32'(2 * k));
`endif
    do_reset("t3b");
    stream(68);
    chk("t3b_stall", 32'(n_stall), 32'd1);
    chk("t3b_ready_low", 32'(n_rdy_low), 32'd1);
    chk("t3b_nvalid", 32'(n_valid), 32'd69);
    do_reset("t4a");
    for (int i = 0; i < 8; i++) send(32'hC0DE_0000 ^ (32'(i) * 32'h1111_1111), i == 4);
    idle(8);
    ref_q = cap_q;
    do_reset("t4b");
    for (int i = 0; i < 8; i++) begin
      if (i == 2) idle(5);
      send(32'hC0DE_0000 ^ (32'(i) * 32'h1111_1111), i == 4);
    end
    idle(8);
    chk("t4_nwords", 32'(cap_q.size()), 32'(ref_q.size()));
    chk("t4_nvalid", 32'(n_valid), 32'd8);
    for (int k = 0; k < ref_q.size() && k < cap_q.size(); k++) chk("t4_same_stream", cap_q[k], ref_q[k]);
    do_reset("t5a");
    send(32'h1111_1111, 1'b0);
    send(32'h2222_2222, 1'b0);
    send(32'h3333_3333, 1'b0);
    do_reset("t5");
    repeat (4) send(32'h0, 1'b1);
    idle(8);
    chk("t5_first", first_word, 32'h0000_0001);
    chk("t5_nvalid", 32'(n_valid), 32'd4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
